// File: rtl/di_host_arbiter_if.sv
// DI host arbiter bus bundle: both host-side DI ports plus the shared slave port.
// The arbiter connects through 'slave'; hosts and the DI slave sit on 'master'.
interface di_host_arbiter_if;
  // host 0 (MicroBlaze)
  logic [15:0] m0_di_term_addr;
  logic [31:0] m0_di_reg_addr;
  logic [31:0] m0_di_len;
  logic [31:0] m0_di_reg_datai;
  logic        m0_di_read_mode;
  logic        m0_di_read_req;
  logic        m0_di_read;
  logic        m0_di_write_mode;
  logic        m0_di_write;
  logic        m0_di_read_rdy;
  logic        m0_di_write_rdy;
  logic [31:0] m0_di_reg_datao;
  logic [15:0] m0_di_transfer_status;
  // host 1 (USB/FX)
  logic [15:0] m1_di_term_addr;
  logic [31:0] m1_di_reg_addr;
  logic [31:0] m1_di_len;
  logic [31:0] m1_di_reg_datai;
  logic        m1_di_read_mode;
  logic        m1_di_read_req;
  logic        m1_di_read;
  logic        m1_di_write_mode;
  logic        m1_di_write;
  logic        m1_di_read_rdy;
  logic        m1_di_write_rdy;
  logic [31:0] m1_di_reg_datao;
  logic [15:0] m1_di_transfer_status;
  // shared DI slave port
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic [31:0] di_len;
  logic [31:0] di_reg_datai;
  logic        di_read_mode;
  logic        di_read_req;
  logic        di_read;
  logic        di_write_mode;
  logic        di_write;
  logic        di_read_rdy;
  logic        di_write_rdy;
  logic [31:0] di_reg_datao;
  logic [15:0] di_transfer_status;

  modport slave (
    input  m0_di_term_addr, m0_di_reg_addr, m0_di_len, m0_di_reg_datai,
           m0_di_read_mode, m0_di_read_req, m0_di_read, m0_di_write_mode, m0_di_write,
           m1_di_term_addr, m1_di_reg_addr, m1_di_len, m1_di_reg_datai,
           m1_di_read_mode, m1_di_read_req, m1_di_read, m1_di_write_mode, m1_di_write,
           di_read_rdy, di_write_rdy, di_reg_datao, di_transfer_status,
    output m0_di_read_rdy, m0_di_write_rdy, m0_di_reg_datao, m0_di_transfer_status,
           m1_di_read_rdy, m1_di_write_rdy, m1_di_reg_datao, m1_di_transfer_status,
           di_term_addr, di_reg_addr, di_len, di_reg_datai,
           di_read_mode, di_read_req, di_read, di_write_mode, di_write
  );

  modport master (
    output m0_di_term_addr, m0_di_reg_addr, m0_di_len, m0_di_reg_datai,
           m0_di_read_mode, m0_di_read_req, m0_di_read, m0_di_write_mode, m0_di_write,
           m1_di_term_addr, m1_di_reg_addr, m1_di_len, m1_di_reg_datai,
           m1_di_read_mode, m1_di_read_req, m1_di_read, m1_di_write_mode, m1_di_write,
           di_read_rdy, di_write_rdy, di_reg_datao, di_transfer_status,
    input  m0_di_read_rdy, m0_di_write_rdy, m0_di_reg_datao, m0_di_transfer_status,
           m1_di_read_rdy, m1_di_write_rdy, m1_di_reg_datao, m1_di_transfer_status,
           di_term_addr, di_reg_addr, di_len, di_reg_datai,
           di_read_mode, di_read_req, di_read, di_write_mode, di_write
  );
endinterface

// File: rtl/di_host_arbiter.sv
// Two-host round-robin arbiter for the DI terminal/register bus.
// Grants whole mode windows, replays read_req pulses seen while a host waited.
// Optional build macro DI_ARB_TIMEOUT_EN: force release of an idle owner after
// TIMEOUT_CYCLES owned cycles without a read/write strobe (sticky timeout_flag).
module di_host_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 11
) (
  input  logic              ifclk,
  input  logic              reset,
  di_host_arbiter_if.slave  bus,
  output logic [1:0]        grant,
  output logic              timeout_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic        last;
  logic        pend0, pend1;
  logic        req0, req1;
  logic        to_expire;

  logic [15:0] term_q, mux_term;
  logic [31:0] reg_q, mux_reg;
  logic [31:0] len_q, mux_len;
  logic [31:0] datai_q, mux_datai;
  logic        mux_rmode, mux_rreq, mux_rd, mux_wmode, mux_wr;

  assign req0  = bus.m0_di_read_mode | bus.m0_di_write_mode | bus.m0_di_read_req;
  assign req1  = bus.m1_di_read_mode | bus.m1_di_write_mode | bus.m1_di_read_req;
  assign grant = state;

  // state register
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next owner: round-robin on ties, direct hand-over on release
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0: if (!req0 || to_expire) state_nxt = req1 ? OWN1 : IDLE;
      OWN1: if (!req1 || to_expire) state_nxt = req0 ? OWN0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last winner, updated whenever a new owner is installed
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (state_nxt != state) begin
      if (state_nxt == OWN0)      last <= 1'b0;
      else if (state_nxt == OWN1) last <= 1'b1;
    end
  end

  // pending read_req: captured while waiting, consumed in the first owned cycle
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (state == OWN0)          pend0 <= 1'b0;
      else if (bus.m0_di_read_req) pend0 <= 1'b1;
      if (state == OWN1)          pend1 <= 1'b0;
      else if (bus.m1_di_read_req) pend1 <= 1'b1;
    end
  end

  // slave-side mux; address/data fall back to the held copy of the last owner when idle
  always_comb begin
    mux_term  = term_q;
    mux_reg   = reg_q;
    mux_len   = len_q;
    mux_datai = datai_q;
    mux_rmode = 1'b0;
    mux_rreq  = 1'b0;
    mux_rd    = 1'b0;
    mux_wmode = 1'b0;
    mux_wr    = 1'b0;
    case (state)
      OWN0: begin
        mux_term  = bus.m0_di_term_addr;
        mux_reg   = bus.m0_di_reg_addr;
        mux_len   = bus.m0_di_len;
        mux_datai = bus.m0_di_reg_datai;
        mux_rmode = bus.m0_di_read_mode;
        mux_rreq  = bus.m0_di_read_req | pend0;
        mux_rd    = bus.m0_di_read;
        mux_wmode = bus.m0_di_write_mode;
        mux_wr    = bus.m0_di_write;
      end
      OWN1: begin
        mux_term  = bus.m1_di_term_addr;
        mux_reg   = bus.m1_di_reg_addr;
        mux_len   = bus.m1_di_len;
        mux_datai = bus.m1_di_reg_datai;
        mux_rmode = bus.m1_di_read_mode;
        mux_rreq  = bus.m1_di_read_req | pend1;
        mux_rd    = bus.m1_di_read;
        mux_wmode = bus.m1_di_write_mode;
        mux_wr    = bus.m1_di_write;
      end
      default: ;
    endcase
  end

  // hold registers: track the owner's address/data so idle cycles keep them stable
  // (a plain mux by 'last' would not give zero outputs out of reset)
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      term_q  <= '0;
      reg_q   <= '0;
      len_q   <= '0;
      datai_q <= '0;
    end else if (state != IDLE) begin
      term_q  <= mux_term;
      reg_q   <= mux_reg;
      len_q   <= mux_len;
      datai_q <= mux_datai;
    end
  end

  assign bus.di_term_addr  = mux_term;
  assign bus.di_reg_addr   = mux_reg;
  assign bus.di_len        = mux_len;
  assign bus.di_reg_datai  = mux_datai;
  assign bus.di_read_mode  = mux_rmode;
  assign bus.di_read_req   = mux_rreq;
  assign bus.di_read       = mux_rd;
  assign bus.di_write_mode = mux_wmode;
  assign bus.di_write      = mux_wr;

  assign bus.m0_di_read_rdy        = (state == OWN0) & bus.di_read_rdy;
  assign bus.m0_di_write_rdy       = (state == OWN0) & bus.di_write_rdy;
  assign bus.m1_di_read_rdy        = (state == OWN1) & bus.di_read_rdy;
  assign bus.m1_di_write_rdy       = (state == OWN1) & bus.di_write_rdy;
  assign bus.m0_di_reg_datao       = bus.di_reg_datao;
  assign bus.m1_di_reg_datao       = bus.di_reg_datao;
  assign bus.m0_di_transfer_status = bus.di_transfer_status;
  assign bus.m1_di_transfer_status = bus.di_transfer_status;

`ifdef DI_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            owner_strobe;

  assign owner_strobe = ((state == OWN0) && (bus.m0_di_read || bus.m0_di_write)) ||
                        ((state == OWN1) && (bus.m1_di_read || bus.m1_di_write));
  assign to_expire    = (state != IDLE) && !owner_strobe &&
                        (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // idle-owner counter: restarts on owner change or any owner strobe
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset)                                               to_cnt <= '0;
    else if (state_nxt != state || owner_strobe || state == IDLE) to_cnt <= '0;
    else                                                     to_cnt <= to_cnt + TO_W'(1);
  end

  // sticky timeout indication
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset)          timeout_flag <= 1'b0;
    else if (to_expire) timeout_flag <= 1'b1;
  end
`else
  assign to_expire    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_di_host_arbiter.sv
// Directed, table-driven bench for di_host_arbiter plus hand sequences for
// asynchronous reset and the idle-owner timeout.
module tb_di_host_arbiter;

  logic ifclk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] grant;
  logic timeout_flag;

  int n_vec = 0;
  int n_bad = 0;

  di_host_arbiter_if bus ();

  di_host_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .ifclk        (ifclk),
    .reset        (reset),
    .bus          (bus),
    .grant        (grant),
    .timeout_flag (timeout_flag)
  );

  always #5 ifclk = ~ifclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // host bits {read_mode, write_mode, read_req, read, write}; slave {read_rdy, write_rdy}
  // exp_d {read_req, read_mode, write_mode, read, write}; exp_rdy {m0rr, m0wr, m1rr, m1wr}
  typedef struct {
    string       name;
    logic [4:0]  h0;
    logic [4:0]  h1;
    logic [1:0]  sl;
    logic [1:0]  gnt;
    logic [4:0]  d;
    logic [3:0]  rdy;
    logic [15:0] ta;
    logic [31:0] dd;
  } vec_t;

  vec_t vq[$];

  task automatic drive(input logic [4:0] h0, input logic [4:0] h1, input logic [1:0] sl);
    bus.m0_di_read_mode  = h0[4];
    bus.m0_di_write_mode = h0[3];
    bus.m0_di_read_req   = h0[2];
    bus.m0_di_read       = h0[1];
    bus.m0_di_write      = h0[0];
    bus.m1_di_read_mode  = h1[4];
    bus.m1_di_write_mode = h1[3];
    bus.m1_di_read_req   = h1[2];
    bus.m1_di_read       = h1[1];
    bus.m1_di_write      = h1[0];
    bus.di_read_rdy      = sl[1];
    bus.di_write_rdy     = sl[0];
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] observe();
    return {4'h0, grant,
            bus.di_read_req, bus.di_read_mode, bus.di_write_mode, bus.di_read, bus.di_write,
            bus.m0_di_read_rdy, bus.m0_di_write_rdy, bus.m1_di_read_rdy, bus.m1_di_write_rdy,
            bus.di_term_addr, bus.di_reg_datai, timeout_flag};
  endfunction

  task automatic cyc();
    @(posedge ifclk);
    #1;
  endtask

  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;

  int owned;

  initial begin
    vq.push_back(vec_t'{"rst_idle",       5'b00000, 5'b00000, 2'b11, 2'b00, 5'b00000, 4'b0000, 16'h0000, 32'h0});
    vq.push_back(vec_t'{"m0_req",         5'b10100, 5'b00000, 2'b11, 2'b00, 5'b00000, 4'b0000, 16'h0000, 32'h0});
    vq.push_back(vec_t'{"m0_replay",      5'b10000, 5'b00000, 2'b11, 2'b01, 5'b11000, 4'b1100, 16'h1000, D0});
    vq.push_back(vec_t'{"m0_read",        5'b10010, 5'b00000, 2'b11, 2'b01, 5'b01010, 4'b1100, 16'h1000, D0});
    vq.push_back(vec_t'{"m1_wr_blocked",  5'b10000, 5'b01001, 2'b11, 2'b01, 5'b01000, 4'b1100, 16'h1000, D0});
    vq.push_back(vec_t'{"m0_release",     5'b00000, 5'b01001, 2'b11, 2'b01, 5'b00000, 4'b1100, 16'h1000, D0});
    vq.push_back(vec_t'{"m1_owns_wr",     5'b00000, 5'b01001, 2'b11, 2'b10, 5'b00101, 4'b0011, 16'h2000, D1});
    vq.push_back(vec_t'{"m1_release",     5'b00000, 5'b00000, 2'b11, 2'b10, 5'b00000, 4'b0011, 16'h2000, D1});
    vq.push_back(vec_t'{"idle_hold",      5'b00000, 5'b00000, 2'b11, 2'b00, 5'b00000, 4'b0000, 16'h2000, D1});
    vq.push_back(vec_t'{"both_req",       5'b10000, 5'b10000, 2'b00, 2'b00, 5'b00000, 4'b0000, 16'h2000, D1});
    vq.push_back(vec_t'{"m1_pend",        5'b10000, 5'b10100, 2'b00, 2'b01, 5'b01000, 4'b0000, 16'h1000, D0});
    vq.push_back(vec_t'{"m0_rel_m1_wait", 5'b00000, 5'b10000, 2'b10, 2'b01, 5'b00000, 4'b1000, 16'h1000, D0});
    vq.push_back(vec_t'{"m1_replay",      5'b00000, 5'b10000, 2'b10, 2'b10, 5'b11000, 4'b0010, 16'h2000, D1});
    vq.push_back(vec_t'{"m1_read_once",   5'b00000, 5'b10010, 2'b10, 2'b10, 5'b01010, 4'b0010, 16'h2000, D1});
    vq.push_back(vec_t'{"m1_rel_m0_wait", 5'b01000, 5'b00000, 2'b10, 2'b10, 5'b00000, 4'b0010, 16'h2000, D1});
    vq.push_back(vec_t'{"m0_owns_wr",     5'b01001, 5'b00000, 2'b01, 2'b01, 5'b00101, 4'b0100, 16'h1000, D0});
    vq.push_back(vec_t'{"m0_rel_m1_req",  5'b00000, 5'b10000, 2'b00, 2'b01, 5'b00000, 4'b0000, 16'h1000, D0});
    vq.push_back(vec_t'{"m1_holds_fair",  5'b10000, 5'b10000, 2'b00, 2'b10, 5'b01000, 4'b0000, 16'h2000, D1});
    vq.push_back(vec_t'{"m1_rel_to_m0",   5'b10000, 5'b00000, 2'b00, 2'b10, 5'b00000, 4'b0000, 16'h2000, D1});
    vq.push_back(vec_t'{"m0_owns",        5'b10000, 5'b00000, 2'b00, 2'b01, 5'b01000, 4'b0000, 16'h1000, D0});
    vq.push_back(vec_t'{"m0_rel",         5'b00000, 5'b00000, 2'b00, 2'b01, 5'b00000, 4'b0000, 16'h1000, D0});
    vq.push_back(vec_t'{"m0_rereq",       5'b10000, 5'b00000, 2'b00, 2'b00, 5'b00000, 4'b0000, 16'h1000, D0});
    vq.push_back(vec_t'{"m0_regrant",     5'b10000, 5'b00000, 2'b00, 2'b01, 5'b01000, 4'b0000, 16'h1000, D0});
    vq.push_back(vec_t'{"m0_rel2",        5'b00000, 5'b00000, 2'b00, 2'b01, 5'b00000, 4'b0000, 16'h1000, D0});
    vq.push_back(vec_t'{"idle_end",       5'b00000, 5'b00000, 2'b00, 2'b00, 5'b00000, 4'b0000, 16'h1000, D0});

    bus.m0_di_term_addr    = 16'h1000;
    bus.m0_di_reg_addr     = 32'h0000_0100;
    bus.m0_di_len          = 32'd4;
    bus.m0_di_reg_datai    = D0;
    bus.m1_di_term_addr    = 16'h2000;
    bus.m1_di_reg_addr     = 32'h0000_0200;
    bus.m1_di_len          = 32'd8;
    bus.m1_di_reg_datai    = D1;
    bus.di_reg_datao       = 32'hCAFE_0001;
    bus.di_transfer_status = 16'h5A5A;
    drive(5'b0, 5'b0, 2'b00);

    repeat (3) @(posedge ifclk);
    #1 reset = 1'b0;

    // table: inputs applied after an edge, outputs sampled on the falling edge
    foreach (vq[i]) begin
      drive(vq[i].h0, vq[i].h1, vq[i].sl);
      @(negedge ifclk);
      check(vq[i].name, observe(),
            {4'h0, vq[i].gnt, vq[i].d, vq[i].rdy, vq[i].ta, vq[i].dd, 1'b0});
      if (i == 6)
        check("m1_bcast_datao", {bus.m0_di_reg_datao, bus.m0_di_transfer_status, bus.m1_di_reg_datao, bus.m1_di_transfer_status},
              {32'hCAFE_0001, 16'h5A5A, 32'hCAFE_0001, 16'h5A5A});
      cyc();
    end

    // asynchronous reset during an m0 write window with m1 pending
    drive(5'b01000, 5'b00000, 2'b00);
    cyc();
    drive(5'b01000, 5'b00100, 2'b00);
    @(negedge ifclk);
    check("rst_pre_own", {62'h0, grant}, 64'h1);
    check("rst_pre_wmode", {63'h0, bus.di_write_mode}, 64'h1);
    cyc();
    drive(5'b01000, 5'b00000, 2'b00);
    @(negedge ifclk);
    #1 reset = 1'b1;
    #1;
    check("rst_async", {44'h0, grant, bus.di_write_mode, bus.di_term_addr, timeout_flag},
          {44'h0, 2'b00, 1'b0, 16'h0000, 1'b0});
    @(posedge ifclk);
    #1 reset = 1'b0;
    drive(5'b00000, 5'b10000, 2'b00);
    @(negedge ifclk);
    check("rst_post_idle", {62'h0, grant}, 64'h0);
    cyc();
    @(negedge ifclk);
    check("rst_pend_clear", {59'h0, grant, bus.di_read_req, bus.di_read_mode, bus.di_write_mode},
          {59'h0, 2'b10, 1'b0, 1'b1, 1'b0});
    cyc();

    // owner holds write_mode with no strobes
    drive(5'b0, 5'b0, 2'b00);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(5'b01000, 5'b00000, 2'b00);
    owned = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ifclk);
      if (grant == 2'b01) owned++;
      else if (owned > 0) break;
      cyc();
    end
`ifdef DI_ARB_TIMEOUT_EN
    check("to_owned_cycles", 64'(owned), 64'd16);
    check("to_release_flag", {61'h0, grant, timeout_flag}, {61'h0, 2'b00, 1'b1});
`else
    check("hold_owned_cycles", 64'(owned), 64'd39);
    check("hold_no_flag", {61'h0, grant, timeout_flag}, {61'h0, 2'b01, 1'b0});
`endif
    drive(5'b0, 5'b0, 2'b00);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
